// File: rtl/router_idata_buffer.sv
// router_idata_buffer: WIDTH x DEPTH input flit FIFO with valid/ready, pop credit and sticky overflow flag.
// Optional zero-latency empty bypass enabled by defining ROUTER_IDATA_BYPASS_EN.
module router_idata_buffer #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] count,
   output logic             credit,
   output logic             ovf_err
);
   localparam int PW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic empty, full, push, pop, wr, rd;
   assign empty = count == '0;
   assign full = count == CNT_W'(DEPTH);
   assign in_ready = reset & ~full;
   assign push = in_valid & in_ready;
   assign pop = out_valid & out_ready;
`ifdef ROUTER_IDATA_BYPASS_EN
   assign out_valid = ~empty | (reset & in_valid);
   assign out_data = empty ? (reset ? in_data : '0) : mem[rd_ptr];
   assign rd = pop & ~empty;
   assign wr = push & ~(empty & pop);
`else
   assign out_valid = ~empty;
   assign out_data = empty ? '0 : mem[rd_ptr];
   assign rd = pop;
   assign wr = push;
`endif
   // storage write; contents are not cleared by reset
   always_ff @(posedge clk)
      if (wr) mem[wr_ptr] <= in_data;
   // pointers, occupancy, credit pulse and sticky overflow
   always_ff @(posedge clk)
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
         credit <= 1'b0;
         ovf_err <= 1'b0;
      end else begin
         if (wr) wr_ptr <= wr_ptr + PW'(1);
         if (rd) rd_ptr <= rd_ptr + PW'(1);
         count <= (wr & ~rd) ? count + CNT_W'(1) : (rd & ~wr) ? count - CNT_W'(1) : count;
         credit <= pop;
         ovf_err <= ovf_err | (in_valid & ~in_ready);
      end
endmodule

// File: tb/tb_router_idata_buffer.sv
// tb_router_idata_buffer: queue-model scoreboard plus directed literal checks for router_idata_buffer.
module tb_router_idata_buffer;
   localparam int DEPTH = 4;
   logic clk = 0, reset = 0, in_valid = 0, out_ready = 0;
   logic in_ready, out_valid, credit, ovf_err;
   logic [31:0] in_data = 0, out_data;
   logic [2:0] count;
   int n_chk = 0, n_fail = 0;
   bit go = 0;
   logic [31:0] q[$];
   bit m_credit = 0, m_ovf = 0;

   router_idata_buffer #(.WIDTH(32), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .count(count),
      .credit(credit), .ovf_err(ovf_err));

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // reference model: a FIFO queue updated from the rules at each rising edge
   always @(posedge clk) begin
      if (!reset) begin
         q.delete();
         m_credit = 0;
         m_ovf = 0;
      end else begin
         bit bypass_take, mpop, mpush;
         bypass_take = 0;
`ifdef ROUTER_IDATA_BYPASS_EN
         bypass_take = q.size() == 0 && in_valid && out_ready;
`endif
         mpop = (q.size() > 0 && out_ready) || bypass_take;
         mpush = in_valid && q.size() < DEPTH && !bypass_take;
         if (in_valid && q.size() == DEPTH) m_ovf = 1;
         m_credit = mpop;
         if (mpop && !bypass_take) void'(q.pop_front());
         if (mpush) q.push_back(in_data);
      end
   end

   // every-cycle comparison of all outputs against the model
   always @(negedge clk) if (go) begin
      logic [31:0] e_data;
      bit e_valid;
      e_valid = q.size() > 0;
      e_data = q.size() > 0 ? q[0] : 32'h0;
`ifdef ROUTER_IDATA_BYPASS_EN
      if (q.size() == 0 && reset) begin
         e_valid = in_valid;
         e_data = in_data;
      end
`endif
      check("m_in_ready", {31'b0, in_ready}, {31'b0, reset && q.size() < DEPTH});
      check("m_out_valid", {31'b0, out_valid}, {31'b0, e_valid});
      check("m_out_data", out_data, e_data);
      check("m_count", {29'b0, count}, q.size());
      check("m_credit", {31'b0, credit}, {31'b0, m_credit});
      check("m_ovf_err", {31'b0, ovf_err}, {31'b0, m_ovf});
   end

   initial begin
      repeat (2) step();
      go = 1;
      check("rst_count", {29'b0, count}, 0);
      check("rst_out_valid", {31'b0, out_valid}, 0);
      check("rst_out_data", out_data, 0);
      check("rst_in_ready", {31'b0, in_ready}, 0);
      reset = 1;
      step();
      check("idle_in_ready", {31'b0, in_ready}, 1);
      check("idle_credit", {31'b0, credit}, 0);
      check("idle_ovf", {31'b0, ovf_err}, 0);
      // single flit
      in_valid = 1; in_data = 32'hDEADBEEF;
      step();
      in_valid = 0;
      check("one_valid", {31'b0, out_valid}, 1);
      check("one_data", out_data, 32'hDEADBEEF);
      check("one_count", {29'b0, count}, 1);
      check("one_credit_pre", {31'b0, credit}, 0);
      out_ready = 1;
      step();
      out_ready = 0;
      check("one_count_after", {29'b0, count}, 0);
      check("one_credit", {31'b0, credit}, 1);
      step();
      check("one_credit_end", {31'b0, credit}, 0);
      // fill to full then overflow attempt
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1; in_data = i;
         step();
      end
      check("full_count", {29'b0, count}, 4);
      check("full_in_ready", {31'b0, in_ready}, 0);
      in_data = 5;
      step();
      in_valid = 0;
      check("ovf_set", {31'b0, ovf_err}, 1);
      check("ovf_count", {29'b0, count}, 4);
      step();
      check("ovf_sticky", {31'b0, ovf_err}, 1);
      out_ready = 1;
      for (int i = 1; i <= 4; i++) begin
         check("drain_data", out_data, i);
         step();
         check("drain_credit", {31'b0, credit}, 1);
      end
      out_ready = 0;
      check("drain_count", {29'b0, count}, 0);
      step();
      check("drain_credit_end", {31'b0, credit}, 0);
      check("ovf_still", {31'b0, ovf_err}, 1);
      // simultaneous push/pop at count 2
      for (int i = 0; i < 2; i++) begin
         in_valid = 1; in_data = 32'h10 + i;
         step();
      end
      out_ready = 1;
      for (int k = 0; k < 8; k++) begin
         in_data = 32'h12 + k;
         #1;
         check("sim_data", out_data, 32'h10 + k);
         step();
         check("sim_count", {29'b0, count}, 2);
      end
      in_valid = 0;
      check("sim_tail0", out_data, 32'h18);
      step();
      check("sim_tail1", out_data, 32'h19);
      step();
      out_ready = 0;
      check("sim_empty", {29'b0, count}, 0);
      step();
      // reset mid-operation
      for (int i = 0; i < 3; i++) begin
         in_valid = 1; in_data = 32'h31 + i;
         step();
      end
      in_valid = 0;
      check("mid_count", {29'b0, count}, 3);
      reset = 0; out_ready = 1;
      step();
      reset = 1; out_ready = 0;
      check("mid_rst_count", {29'b0, count}, 0);
      check("mid_rst_valid", {31'b0, out_valid}, 0);
      check("mid_rst_credit", {31'b0, credit}, 0);
      check("mid_rst_ovf", {31'b0, ovf_err}, 0);
      in_valid = 1; in_data = 32'hA5;
      step();
      in_valid = 0;
      check("mid_credit", {31'b0, credit}, 0);
      check("mid_head", out_data, 32'hA5);
      check("mid_head_count", {29'b0, count}, 1);
      out_ready = 1;
      step();
      out_ready = 0;
      step();
`ifdef ROUTER_IDATA_BYPASS_EN
      in_valid = 1; in_data = 32'h77; out_ready = 1;
      #1;
      check("byp_valid", {31'b0, out_valid}, 1);
      check("byp_data", out_data, 32'h77);
      step();
      in_valid = 0; out_ready = 0;
      check("byp_count", {29'b0, count}, 0);
      check("byp_credit", {31'b0, credit}, 1);
      step();
`endif
      repeat (2) step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
